// File: rtl/sram_ctrl.sv
// sram_ctrl: each 32-bit MEM load/store becomes two 16-bit async-SRAM phases of PHASE_CYCLES cycles; ready=1 at 2*PHASE_CYCLES+1 cycles
// after the request, and ~ready freezes the pipeline until then. Macro SRAM_CACHE_EN adds a one-entry write-through read cache.
module sram_ctrl #(
  parameter int N            = 32,
  parameter int BASE_ADDR    = 1024,
  parameter int PHASE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [N-1:0] address,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         ready,
  inout  wire  [15:0]  SRAM_DQ,
  output logic [17:0]  SRAM_ADDR,
  output logic         SRAM_WE_N,
  output logic         SRAM_OE_N
);
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic          is_wr_q, is_wr_d;

  logic [N-1:0]  off_q;
  logic [16:0]   word_q;
  logic          req, hit, phase_end, hi_half;
  logic          dq_oe;
  logic [15:0]   dq_out;
  logic          unused_off;

  assign req        = wr_en | rd_en;
  assign off_q      = addr_q - N'(BASE_ADDR);
  assign word_q     = off_q[18:2];
  assign unused_off = ^{off_q[N-1:19], off_q[1:0]};
  assign phase_end  = (cnt_q == CNT_LAST);
  assign hi_half    = (state_q == HIGH);

  // The bus is released whenever OE_N may be low: only write phases drive DQ.
  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

`ifdef SRAM_CACHE_EN
  logic          cache_vld_q, cache_vld_d;
  logic [16:0]   cache_tag_q, cache_tag_d;
  logic [N-1:0]  cache_dat_q, cache_dat_d;
  logic [N-1:0]  off_in;
  logic [16:0]   word_in;
  logic          unused_in;

  assign off_in    = address - N'(BASE_ADDR);
  assign word_in   = off_in[18:2];
  assign unused_in = ^{off_in[N-1:19], off_in[1:0]};
  assign hit       = (state_q == IDLE) && rd_en && !wr_en && cache_vld_q && (cache_tag_q == word_in);
  assign rdata     = hit ? cache_dat_q : rdata_q;

  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_tag_d = cache_tag_q;
    cache_dat_d = cache_dat_q;
    if (state_q == DONE) begin
      if (!is_wr_q) begin
        cache_vld_d = 1'b1;
        cache_tag_d = word_q;
        cache_dat_d = rdata_q;
      end else if (cache_vld_q && (cache_tag_q == word_q)) begin
        cache_dat_d = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_q <= 1'b0;
      cache_tag_q <= '0;
      cache_dat_q <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_tag_q <= cache_tag_d;
      cache_dat_q <= cache_dat_d;
    end
  end
`else
  assign hit   = 1'b0;
  assign rdata = rdata_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_wr_d   = is_wr_q;
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = '0;
    unique case (state_q)
      IDLE: begin
        ready = !req || hit;
        if (hit) begin
          // Keep the hit value visible after the request goes away.
          rdata_d = rdata;
        end else if (req) begin
          addr_d  = address;
          wdata_d = wdata;
          is_wr_d = wr_en;
          cnt_d   = '0;
          state_d = LOW;
        end
      end
      LOW, HIGH: begin
        SRAM_ADDR = {word_q, hi_half};
        if (is_wr_q) begin
          SRAM_WE_N = 1'b0;
          dq_oe     = 1'b1;
          dq_out    = hi_half ? wdata_q[31:16] : wdata_q[15:0];
        end else begin
          SRAM_OE_N = 1'b0;
          if (phase_end) begin
            if (hi_half) rdata_d[31:16] = SRAM_DQ;
            else         rdata_d[15:0]  = SRAM_DQ;
          end
        end
        if (phase_end) begin
          cnt_d   = '0;
          state_d = hi_half ? DONE : HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_wr_q <= is_wr_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: transaction-level model (cycle offsets from request, word-addressed memory, optional cache) plus directed literals.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int P    = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready, SRAM_WE_N, SRAM_OE_N;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;

  logic [15:0] sram [0:255];
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.N(32), .BASE_ADDR(BASE), .PHASE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  // External SRAM: drives the bus on output enable, stores on write enable.
  assign SRAM_DQ = !SRAM_OE_N ? sram[SRAM_ADDR[7:0]] : 16'bz;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_DQ;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[18:2];
  endfunction

  // Reference model state
  bit          m_busy, m_wr;
  int          m_k;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] ref_mem [int];
  bit          c_vld;
  logic [16:0] c_tag;
  logic [31:0] c_dat;

  always @(negedge clk) begin
    logic [31:0] e_rdata;
    logic [17:0] e_addr;
    logic [16:0] w;
    bit          e_ready, e_we_n, e_oe_n, chk_rd, hit, half;
    if (!rst) begin
      m_busy  = 1'b0;
      m_rdata = '0;
      c_vld   = 1'b0;
      check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      check("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
      check("rst_rdata", rdata, 32'd0);
    end else begin
      e_we_n = 1'b1; e_oe_n = 1'b1; e_addr = '0; chk_rd = 1'b1; e_ready = 1'b0; hit = 1'b0;
      if (!m_busy) begin
`ifdef SRAM_CACHE_EN
        hit = rd_en && !wr_en && c_vld && (c_tag == word_of(address));
`endif
        if (hit) begin
          e_ready = 1'b1;
          m_rdata = c_dat;
        end else if (wr_en || rd_en) begin
          m_busy = 1'b1; m_k = 1; m_wr = wr_en; m_addr = address; m_wdata = wdata;
        end else begin
          e_ready = 1'b1;
        end
      end else if (m_k <= 2*P) begin
        half   = (m_k > P);
        e_addr = {word_of(m_addr), half};
        if (m_wr) begin
          e_we_n = 1'b0;
          check("dq_write", {16'd0, SRAM_DQ}, {16'd0, half ? m_wdata[31:16] : m_wdata[15:0]});
        end else begin
          e_oe_n = 1'b0;
          chk_rd = 1'b0;
        end
        m_k++;
      end else begin
        e_ready = 1'b1;
        w = word_of(m_addr);
        if (m_wr) begin
          ref_mem[int'(w)] = m_wdata;
          if (c_vld && c_tag == w) c_dat = m_wdata;
        end else begin
          m_rdata = ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'd0;
`ifdef SRAM_CACHE_EN
          c_vld = 1'b1; c_tag = w; c_dat = m_rdata;
`endif
        end
        m_busy = 1'b0;
      end
      e_rdata = m_rdata;
      check("ready", {31'd0, ready}, {31'd0, e_ready});
      check("we_n", {31'd0, SRAM_WE_N}, {31'd0, e_we_n});
      check("oe_n", {31'd0, SRAM_OE_N}, {31'd0, e_oe_n});
      check("sram_addr", {14'd0, SRAM_ADDR}, {14'd0, e_addr});
      if (!SRAM_OE_N) check("no_dq_drive_on_read", {31'd0, SRAM_WE_N}, 32'd1);
      if (chk_rd) check("rdata", rdata, e_rdata);
    end
  end

  // Called just after a rising edge; returns just after the edge ending the ready cycle.
  task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output longint rcyc);
    wr_en = wr; rd_en = rd; address = a; wdata = d;
    lat = -1; rcyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready) begin
        lat  = c;
        rcyc = cyc;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: no ready within 40 cycles, addr %h", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int     lat;
    longint r1, r2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Reset abandons a write in its low phase.
    wr_en = 1'b1; address = 32'd1100; wdata = 32'hCAFEF00D;
    @(posedge clk); #2;
    check("pre_rst_we_n", {31'd0, SRAM_WE_N}, 32'd0);
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("async_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("async_rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    check("post_rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, r1);
    go_idle();
    check("store_lat", lat, 32'd5);
    check("store_half0", {16'd0, sram[0]}, 32'h0000BEEF);
    check("store_half1", {16'd0, sram[1]}, 32'h0000DEAD);
    @(posedge clk); #1;

    do_req(1'b0, 1'b1, 32'd1024, 32'd0, lat, r1);
    go_idle();
    check("load_lat", lat, 32'd5);
    check("load_data", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    do_req(1'b1, 1'b1, 32'd1032, 32'h12345678, lat, r1);
    go_idle();
    check("prio_lat", lat, 32'd5);
    check("prio_half4", {16'd0, sram[4]}, 32'h00005678);
    check("prio_half5", {16'd0, sram[5]}, 32'h00001234);
    check("prio_rdata_kept", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    do_req(1'b1, 1'b0, 32'd1028, 32'hA5A55A5A, lat, r1);
    do_req(1'b0, 1'b1, 32'd1028, 32'd0, lat, r2);
    go_idle();
    check("b2b_gap", 32'(r2 - r1), 32'd6);
    check("b2b_data", rdata, 32'hA5A55A5A);
    @(posedge clk); #1;

    do_req(1'b0, 1'b1, 32'd1035, 32'd0, lat, r1);
    go_idle();
    check("low_bits_ignored", rdata, 32'h12345678);
    @(posedge clk); #1;

`ifdef SRAM_CACHE_EN
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, lat, r1);
    go_idle();
    check("cache_miss_lat", lat, 32'd5);
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, lat, r1);
    go_idle();
    check("cache_hit_lat", lat, 32'd0);
    check("cache_hit_data", rdata, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'd1024, 32'h00000001, lat, r1);
    go_idle();
    do_req(1'b0, 1'b1, 32'd1024, 32'd0, lat, r1);
    go_idle();
    check("cache_wt_lat", lat, 32'd0);
    check("cache_wt_data", rdata, 32'h00000001);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Sits directly downstream of the MEM stage. Replaces its internal data memory with an external 16-bit asynchronous SRAM.
- Converts each 32-bit load or store from MEM into two 16-bit SRAM accesses with programmable wait states.
- Drives a ready signal that the hazard/freeze logic uses to stall the whole pipeline while an access is in flight.

Parameters:
- N, 32, CPU data/address width.
- BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0.
- PHASE_CYCLES, 2, cycles each 16-bit half-access is held on the SRAM bus (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- wr_en  input  1  store request from MEM stage (MEM_W_EN)
- rd_en  input  1  load request from MEM stage (MEM_R_EN)
- address  input  N  byte address (ALU result)
- wdata  input  N  store data (Val_Rm)
- rdata  output  N  load result to MEM/WB register
- ready  output  1  access complete; pipeline freeze = ~ready
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM half-word address
- SRAM_WE_N  output  1  SRAM write enable, active-low
- SRAM_OE_N  output  1  SRAM output enable, active-low

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, rdata=0, latched address/data=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
  - Applies immediately, including mid-access.
- Address mapping: off = address - BASE_ADDR (mod 2^N); word = off[18:2]; low half at {word,0}, high half at {word,1}. off[1:0] ignored.
- States: IDLE → LOW → HIGH → DONE → IDLE.
- IDLE:
  - If wr_en|rd_en: latch address, wdata and op (wr_en has priority if both set); go to LOW; counter=0.
  - ready is combinational: ready = ~(wr_en|rd_en) in IDLE, so no request means ready=1.
- LOW: held PHASE_CYCLES cycles (counter 0..P-1).
  - SRAM_ADDR = low address.
  - Write: SRAM_WE_N=0, DQ = wdata[15:0].
  - Read: SRAM_OE_N=0, DQ=Z; capture DQ into rdata[15:0] on the edge ending counter=P-1.
- HIGH: same as LOW, using the high address and wdata[31:16] / rdata[31:16].
- DONE:
  - One cycle; ready=1; SRAM idle (WE_N=OE_N=1, DQ=Z).
  - Next state IDLE.
  - rdata is stable from DONE until the next read completes; writes do not alter rdata.
- Latency: request first seen in cycle c0; ready=1 in cycle c0+2·P+1. With P=2, that is cycle 5.
- ready=0 in LOW/HIGH and in IDLE with a request pending.
- Input changes while ready=0 are ignored; latched copies are used.
- Back-to-back requests: after DONE, IDLE immediately sees the next request with no extra bubble.
- DQ is driven only during write LOW/HIGH. It is never driven in the same cycle OE_N=0.
- Reset asserted mid-access: the access is abandoned, SRAM contents are undefined for a partial write, and the controller restarts from IDLE.

Optional Feature:
- Macro: SRAM_CACHE_EN.
- Defined: one-entry read cache holding valid, word tag and 32-bit data.
  - Read hit in IDLE: rdata updated combinationally from the cache, ready=1 in the same cycle, no SRAM access.
  - Read miss: fills the entry at DONE.
  - Write to the cached word: updates the cached data (write-through) at DONE.
  - Reset clears valid.
- Undefined: no cache; every read takes the full 2·P+2 cycles.

Test Plan:
- Reset: rst=0 mid-LOW of a write → same cycle WE_N=1, DQ=Z. After release with no request, ready=1 and rdata=0.
- Store: address=1024, wdata=0xDEADBEEF, P=2.
  - Required: SRAM half 0 written 0xBEEF, half 1 written 0xDEAD, each with WE_N low for exactly 2 cycles.
  - ready=1 only in cycle 5.
- Load after store: rd_en, address=1024 → rdata=0xDEADBEEF and ready=1 in cycle 5. OE_N low 4 cycles; DQ never driven by the controller.
- Priority/mapping: rd_en=wr_en=1, address=1032, wdata=0x12345678 → write performed to SRAM_ADDR 4 and 5. rdata unchanged.
- Back-to-back: store 1028 then load 1028 with no idle cycle between them → second ready 6 cycles after the first. The load returns the stored value.
- With SRAM_CACHE_EN:
  - Load 1024 twice → second ready=1 same cycle, SRAM_OE_N stays 1.
  - Then store 0x1 to 1024 and load 1024 → hit returns 0x00000001.
